// File: rtl/ysyx_23060111_imem_resp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060111_imem_resp
// Purpose  : Instruction-memory responder with a word-addressed program store,
//            valid/ready fetch handshakes and programmable response latency.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060111_imem_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        prog_en,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int          c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN   = 32'(4 * DEPTH_WORDS);
    localparam logic [2:0]  c_LAT_M1 = 3'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [2:0]         r_cnt;
    logic [2:0]         w_cnt_nxt;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [31:0]        r_inst;
    logic               r_err;

    logic [31:0]        w_req_off;
    logic [31:0]        w_prog_off;
    logic               w_req_ok;
    logic               w_prog_ok;
    logic [c_IDX_W-1:0] w_req_idx;
    logic [c_IDX_W-1:0] w_prog_idx;
    logic               w_accept;

    // Offsets wrap in 32 bits, so addresses below the base decode as out of range.
    assign w_req_off  = req_addr - ADDR_BASE;
    assign w_req_ok   = (req_addr[1:0] == 2'b00) && (w_req_off < c_SPAN);
    assign w_req_idx  = w_req_off[c_IDX_W+1:2];

    assign w_prog_off = prog_addr - ADDR_BASE;
    assign w_prog_ok  = (prog_addr[1:0] == 2'b00) && (w_prog_off < c_SPAN);
    assign w_prog_idx = w_prog_off[c_IDX_W+1:2];

    assign w_accept   = req_valid && req_ready;

    // Store has no reset so that a loader can fill it while rst is held.
    always_ff @(posedge clk) begin
        if (prog_en && w_prog_ok) begin
            r_mem[w_prog_idx] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Data is sampled at acceptance, so a same-edge write returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst <= 32'h0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_inst <= w_req_ok ? r_mem[w_req_idx] : 32'h0;
            r_err  <= !w_req_ok;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = c_ST_RESP;
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                        w_cnt_nxt   = c_LAT_M1;
                    end
                end
            end
            c_ST_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_comb begin
        req_ready  = (r_state == c_ST_IDLE) && !rst;
        resp_valid = (r_state == c_ST_RESP);
        resp_inst  = r_inst;
        resp_err   = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060111_imem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060111_imem_resp
// Purpose  : Self-checking bench; four responders with latencies 1, 2, 4, 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060111_imem_resp;

    localparam logic [31:0] ADDR_BASE = 32'h8000_0000;
    localparam int          N_DUT     = 4;

    logic        clk;
    logic        rst;
    logic        req_valid  [N_DUT];
    logic [31:0] req_addr   [N_DUT];
    logic        req_ready  [N_DUT];
    logic        resp_valid [N_DUT];
    logic        resp_ready [N_DUT];
    logic [31:0] resp_inst  [N_DUT];
    logic        resp_err   [N_DUT];
    logic        prog_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [1024];

    typedef struct {
        int          inst;
        logic [31:0] addr;
        int          stall;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    generate
        for (genvar g = 0; g < N_DUT; g++) begin : g_dut
            ysyx_23060111_imem_resp #(
                .ADDR_BASE   (ADDR_BASE),
                .DEPTH_WORDS (1024),
                .LATENCY     ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (req_valid[g]),
                .req_addr   (req_addr[g]),
                .req_ready  (req_ready[g]),
                .resp_valid (resp_valid[g]),
                .resp_ready (resp_ready[g]),
                .resp_inst  (resp_inst[g]),
                .resp_err   (resp_err[g]),
                .prog_en    (prog_en),
                .prog_addr  (prog_addr),
                .prog_data  (prog_data)
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 5;
    endfunction

    // Reference: a word exists only for aligned byte addresses inside the 4 KiB window.
    function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        logic [31:0] off;
        off = a - ADDR_BASE;
        if ((a % 4) != 0 || off >= 32'd4096) begin
            e = 1'b1;
            d = 32'h0;
        end else begin
            e = 1'b0;
            d = model_mem[off / 4];
        end
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - ADDR_BASE;
        if ((a % 4) == 0 && off < 32'd4096) model_mem[off / 4] = d;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        w = 32'($urandom_range(0, 1023)) << 2;
        case (r)
            0:       return ADDR_BASE + w + 32'($urandom_range(1, 3));
            1:       return ADDR_BASE + 32'h1000 + w;
            2:       return ADDR_BASE - 32'h4 - w;
            default: return ADDR_BASE + w;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        prog_en   = 1'b1;
        prog_addr = a;
        prog_data = d;
        model_write(a, d);
        @(negedge clk);
        prog_en   = 1'b0;
    endtask

    // Entered and left on a falling edge; outputs are sampled on falling edges.
    task automatic do_fetch(input int k, input logic [31:0] addr, input int stall,
                            input logic [31:0] exp_inst, input logic exp_err,
                            input logic col_wr, input logic [31:0] col_data,
                            input logic wait_wr, input string name);
        int n;
        logic [31:0] wa;
        req_valid[k]  = 1'b1;
        req_addr[k]   = addr;
        resp_ready[k] = 1'b0;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            check({name, " ready timeout"}, {31'h0, req_ready[k]}, 32'h1);
            req_valid[k] = 1'b0;
            return;
        end
        if (col_wr) begin
            prog_en   = 1'b1;
            prog_addr = addr;
            prog_data = col_data;
            model_write(addr, col_data);
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
        prog_en      = 1'b0;
        for (int c = 1; c < lat_of(k); c++) begin
            check({name, " early valid"}, {31'h0, resp_valid[k]}, 32'h0);
            check({name, " ready in wait"}, {31'h0, req_ready[k]}, 32'h0);
            if (wait_wr) begin
                wa = ($urandom_range(0, 1) == 0) ? addr : rand_addr();
                prog_en   = 1'b1;
                prog_addr = wa;
                prog_data = $urandom;
                model_write(wa, prog_data);
            end
            @(negedge clk);
            prog_en = 1'b0;
        end
        for (int s = 0; s <= stall; s++) begin
            check({name, " valid"}, {31'h0, resp_valid[k]}, 32'h1);
            check({name, " inst"}, resp_inst[k], exp_inst);
            check({name, " err"}, {31'h0, resp_err[k]}, {31'h0, exp_err});
            check({name, " ready in resp"}, {31'h0, req_ready[k]}, 32'h0);
            if (s == stall) resp_ready[k] = 1'b1;
            @(negedge clk);
        end
        resp_ready[k] = 1'b0;
        check({name, " valid drop"}, {31'h0, resp_valid[k]}, 32'h0);
        check({name, " idle ready"}, {31'h0, req_ready[k]}, 32'h1);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [32:0] expq [$];
        logic [32:0] q;
        int          acc;
        int          nresp;
        int          last_acc;
        int          cyc;
        bit          adv;
        int          k;

        vecs[0] = '{0, 32'h8000_0000, 0, 32'h0000_0297, 1'b0};
        vecs[1] = '{2, 32'h8000_0004, 3, 32'h0010_0073, 1'b0};
        vecs[2] = '{0, 32'h8000_0002, 0, 32'h0000_0000, 1'b1};
        vecs[3] = '{1, 32'h8000_1000, 1, 32'h0000_0000, 1'b1};
        vecs[4] = '{3, 32'h7FFF_FFFC, 0, 32'h0000_0000, 1'b1};
        vecs[5] = '{2, 32'h8000_0FFC, 2, 32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{3, 32'h8000_0004, 1, 32'h0010_0073, 1'b0};
        vecs[7] = '{1, 32'h8000_0003, 0, 32'h0000_0000, 1'b1};

        rst       = 1'b1;
        prog_en   = 1'b0;
        prog_addr = 32'h0;
        prog_data = 32'h0;
        for (int i = 0; i < N_DUT; i++) begin
            req_valid[i]  = 1'b0;
            req_addr[i]   = 32'h0;
            resp_ready[i] = 1'b0;
        end

        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            check("reset req_ready", {31'h0, req_ready[i]}, 32'h0);
            check("reset resp_valid", {31'h0, resp_valid[i]}, 32'h0);
            check("reset resp_inst", resp_inst[i], 32'h0);
            check("reset resp_err", {31'h0, resp_err[i]}, 32'h0);
        end

        // Store is loaded while reset is still asserted.
        for (int i = 0; i < 1024; i++) prog_write(ADDR_BASE + 32'(i * 4), $urandom);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) check("post-reset req_ready", {31'h0, req_ready[i]}, 32'h1);

        prog_write(32'h8000_0000, 32'h0000_0297);
        prog_write(32'h8000_0004, 32'h0010_0073);
        prog_write(32'h8000_0FFC, 32'hDEAD_BEEF);
        // Illegal writes that would alias onto the words above if not dropped.
        prog_write(32'h8000_0001, 32'hBAD0_BAD0);
        prog_write(32'h8000_1000, 32'hBAD1_BAD1);
        prog_write(32'h8000_1004, 32'hBAD2_BAD2);
        prog_write(32'h7FFF_FFFC, 32'hBAD3_BAD3);

        for (int i = 0; i < 8; i++) begin
            do_fetch(vecs[i].inst, vecs[i].addr, vecs[i].stall, vecs[i].exp_inst,
                     vecs[i].exp_err, 1'b0, 32'h0, 1'b0, $sformatf("vec%0d", i));
        end

        // Same-edge write and accept return the old word.
        prog_write(32'h8000_0000, 32'h1111_1111);
        do_fetch(0, 32'h8000_0000, 0, 32'h1111_1111, 1'b0, 1'b1, 32'h2222_2222, 1'b0, "collision");
        do_fetch(0, 32'h8000_0000, 0, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0, "collision refetch");
        do_fetch(2, 32'h8000_0000, 1, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b1, "write in wait");

        // Reset two cycles into a latency-5 fetch.
        prog_write(32'h8000_0010, 32'hCAFE_F00D);
        req_valid[3]  = 1'b1;
        req_addr[3]   = 32'h8000_0010;
        resp_ready[3] = 1'b1;
        check("midrst pre ready", {31'h0, req_ready[3]}, 32'h1);
        @(negedge clk);
        req_valid[3] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst valid", {31'h0, resp_valid[3]}, 32'h0);
        check("midrst ready", {31'h0, req_ready[3]}, 32'h0);
        check("midrst inst", resp_inst[3], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            check("midrst stale valid", {31'h0, resp_valid[3]}, 32'h0);
            check("midrst idle ready", {31'h0, req_ready[3]}, 32'h1);
            @(negedge clk);
        end
        resp_ready[3] = 1'b0;
        do_fetch(3, 32'h8000_0010, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0, "midrst refetch");
        do_fetch(3, 32'h8000_0FFC, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, "midrst store");

        // Back-to-back streaming on the latency-2 responder.
        acc = 0; nresp = 0; last_acc = -1; cyc = 0; adv = 1'b0;
        req_addr[1]   = 32'h8000_0100;
        req_valid[1]  = 1'b1;
        resp_ready[1] = 1'b1;
        while (nresp < 8 && cyc < 60) begin
            if (resp_valid[1]) begin
                if (expq.size() == 0) begin
                    check("b2b extra response", 32'h1, 32'h0);
                end else begin
                    q = expq.pop_front();
                    check("b2b inst", resp_inst[1], q[31:0]);
                    check("b2b err", {31'h0, resp_err[1]}, {31'h0, q[32]});
                end
                nresp++;
            end
            if (req_ready[1] && req_valid[1]) begin
                if (acc > 0) check("b2b spacing", 32'(cyc - last_acc), 32'd3);
                model_read(req_addr[1], d, e);
                expq.push_back({e, d});
                last_acc = cyc;
                acc++;
                adv = 1'b1;
            end else if (adv) begin
                adv = 1'b0;
                if (acc < 8) req_addr[1] = req_addr[1] + 32'd4;
                else req_valid[1] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b response count", 32'(nresp), 32'd8);
        check("b2b accept count", 32'(acc), 32'd8);
        resp_ready[1] = 1'b0;
        req_valid[1]  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b no extra", {31'h0, resp_valid[1]}, 32'h0);
            @(negedge clk);
        end

        // Randomised fetches against the reference store.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic        cw;
            k  = $urandom_range(0, N_DUT - 1);
            a  = rand_addr();
            cw = ($urandom_range(0, 3) == 0);
            model_read(a, d, e);
            do_fetch(k, a, $urandom_range(0, 3), d, e, cw, $urandom,
                     1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060111_imem_resp.md
Name: ysyx_23060111_imem_resp

Overview:
- Instruction-memory responder: the memory end of the core's fetch interface. The core presents a PC; this block returns the 32-bit instruction word.
- Holds an internal word-addressed program store, loaded by the bench or loader through a write port.
- Serves one fetch at a time using valid/ready handshakes on both the request and the response channels.
- Response latency is programmable, so multi-cycle fetch can be exercised ahead of the core moving off the single-cycle combinational fetch.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0 of the store.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  fetch byte address (PC).
- req_ready  out  1  block can accept a request.
- resp_valid  out  1  resp_inst and resp_err are valid.
- resp_ready  in  1  consumer accepts the response.
- resp_inst  out  32  fetched instruction word.
- resp_err  out  1  misaligned or out-of-range fetch.
- prog_en  in  1  program-store write enable.
- prog_addr  in  32  write byte address, absolute, same mapping as req_addr.
- prog_data  in  32  write data.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; req_ready=0 while rst is high.
  - resp_valid=0, resp_inst=32'h0, resp_err=0, latency counter=0.
  - The program store is not cleared.
- req_ready=1 exactly when state=IDLE and rst=0.
- States: IDLE, WAIT, RESP.
  - IDLE: on req_valid & req_ready, accept the request.
    - Capture the read word, or the error, at this edge.
    - If LATENCY==1, go to RESP; otherwise load counter=LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. Go to RESP on the edge where the counter reaches 1, giving LATENCY cycles total from acceptance.
  - RESP: resp_valid=1. On resp_valid & resp_ready, go to IDLE and drop resp_valid the next cycle.
- Timing:
  - Accept at edge N, so resp_valid=1 from cycle N+LATENCY.
  - Minimum request-to-request spacing is LATENCY+1 cycles: no accept while in RESP.
- Address decode: off = req_addr - ADDR_BASE (32-bit wrap); idx = off[31:2].
  - Error when req_addr[1:0]!=0 or off >= 4*DEPTH_WORDS. In that case resp_err=1 and resp_inst=32'h0.
  - Otherwise resp_err=0 and resp_inst=mem[idx].
- Response hold: while resp_valid=1 and resp_ready=0, resp_inst and resp_err are stable. req_addr changes are ignored after acceptance.
- Between responses, resp_inst and resp_err retain their last values; only resp_valid qualifies them.
- Program writes:
  - When prog_en=1, prog_addr is aligned and in range, mem[idx(prog_addr)] <= prog_data at the edge.
  - Misaligned or out-of-range writes are dropped silently.
  - Writes are accepted in any state, including during reset.
- Write/read collision: a write and an acceptance to the same word in the same edge returns the OLD word, since data is captured at acceptance. A later write during WAIT does not alter the in-flight response.
- Reset mid-operation: in-flight request discarded, outputs forced to reset values immediately. No response is produced for the discarded request.
- Request stability: req_valid may drop before acceptance with no effect. Acceptance occurs only on the handshake edge.

Test Plan:
- Reset release, LATENCY=1:
  - Stimulus: write mem via prog at 0x80000000=0x00000297, 0x80000004=0x00100073. Fetch 0x80000000 with resp_ready=1.
  - Required: resp_valid exactly one cycle after accept, resp_inst=0x00000297, resp_err=0, req_ready=0 in that cycle, req_ready=1 the following cycle.
- LATENCY=4 with backpressure:
  - Stimulus: fetch 0x80000004, hold resp_ready=0 for 3 cycles after resp_valid.
  - Required: resp_valid rises 4 cycles after accept, resp_inst=0x00100073 stable for all 4 valid cycles, req_ready=0 throughout, IDLE one cycle after the handshake.
- Errors:
  - Fetch 0x80000002 -> resp_err=1, resp_inst=0.
  - Fetch 0x80001000 with DEPTH_WORDS=1024 -> resp_err=1.
  - Fetch 0x7FFFFFFC -> resp_err=1 (the subtraction wraps).
- Collision:
  - Stimulus: mem[0]=0x11111111. Accept fetch 0x80000000 on the same edge as prog write 0x22222222 to 0x80000000.
  - Required: response=0x11111111. The next fetch of that address returns 0x22222222.
- Reset mid-flight, LATENCY=5:
  - Stimulus: assert rst 2 cycles after accept, between clock edges.
  - Required: resp_valid=0 and req_ready=0 immediately. After release, req_ready=1, no stale response ever appears, and the store is intact (re-fetch returns prior data).
- Back-to-back fetches, LATENCY=2:
  - Stimulus: req_valid and resp_ready held high, 8 sequential PCs.
  - Required: one accept every 3 cycles, responses in order with matching data, no dropped or duplicated responses.
